dpsram_param: RTL and testbench
===============================

# dpsram_param

Parametrised true dual-port synchronous RAM. It is the next generation of the team's fixed 8×4 dual-port SRAM. Each port can independently read or write, with configurable width and depth, a selectable read-during-write mode, an optional output register stage, per-port read-valid strobes and cross-port collision detection. It sits between datapath blocks that share a scratch buffer and is the standard memory primitive for the next revision of the design.

## Interface
- DW, 8, data width in bits (≥1)
- AW, 4, address width; depth = 2**AW words
- RDW_MODE, 0, same-port read-during-write behaviour: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rs  in  1  reset, asynchronous, active-low
- a_en  in  1  port A access enable
- a_we  in  1  port A write enable; qualified by a_en
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_rdata  out  DW  port A read data
- a_rvalid  out  1  port A read-data-valid strobe
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: same as port A, for port B
- collision  out  1  one-cycle pulse; a same-address conflict occurred

## Operation
- Access type per port:
  - en=0: idle.
  - en=1, we=0: read.
  - en=1, we=1: write.
- Reset (rs=0): asynchronously clears all 2**AW entries to 0. Also zeroes a_rdata, b_rdata, a_rvalid, b_rvalid, collision and any output-stage contents. Any read in flight is discarded.
- Read: rdata ← mem[addr], rvalid=1 for one cycle at the read latency.
- Write: mem[addr] ← wdata. What the writing port returns depends on RDW_MODE:
  - READ_FIRST: rdata = old contents, rvalid=1.
  - WRITE_FIRST: rdata = wdata, rvalid=1.
  - NO_CHANGE: rdata holds, rvalid=0.
- rdata holds its last value whenever rvalid=0.
- Collision: both en=1, a_addr==b_addr, and at least one we=1.
  - Both write: port A data is stored; port B write is dropped.
  - One writes, other reads: the reader gets the pre-write contents regardless of RDW_MODE; the write completes.
  - Both read: not a collision.
- The collision pulse is aligned with the rvalid timing of the colliding access (latency 1 or 2).
- Address arithmetic: addr is used directly, with no wrap logic needed. Every AW-bit value is a legal index.

## Timing
- Read latency: 1 cycle when OUT_REG=0 (data and rvalid in the cycle after the request edge); 2 cycles when OUT_REG=1.
- Fully pipelined: one access per port per cycle, back-to-back, no stall and no handshake back-pressure.
- A write is visible to a read issued on the next cycle, on either port.
- Reset deassertion: the first access is accepted at the first rising edge with rs=1.
- Reset asserted mid-pipeline: outputs go to 0 immediately (asynchronously). Nothing in flight emerges after release.

## Structure
- Package dpsram_pkg holds:
  - RDW mode constants: RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2.
  - A typedef for access type (IDLE, READ, WRITE).
- Sub-module dpsram_rdpipe holds one port's read-data/valid pipeline (1 or 2 stages per OUT_REG, async-reset to 0). It is instantiated once per port. The collision flag uses a third instance of width 1.
- The top level holds the register array, write arbitration and collision compare.

## Test plan
All tests use DW=8, AW=4 unless stated.
- Reset: write 0xA5 at addr 3, pulse rs low for 1 cycle, read addr 3 on both ports -> a_rdata=b_rdata=0x00, rvalid=1 at latency 1.
- Cross-port write/read: A writes 0x5A @addr 1, then B reads addr 1 next cycle -> b_rdata=0x5A, b_rvalid=1 one cycle later. Repeat with OUT_REG=1 -> 2 cycles.
- RDW modes, with addr 2 preloaded with 0x11 and A writing 0x77 @addr 2:
  - READ_FIRST -> a_rdata=0x11, a_rvalid=1.
  - WRITE_FIRST -> a_rdata=0x77, a_rvalid=1.
  - NO_CHANGE -> a_rvalid=0, a_rdata unchanged.
- Dual-write collision: A writes 0x33, B writes 0x44, both @addr 5 -> collision=1 for one cycle; a subsequent read of addr 5 returns 0x33.
- Write/read collision: addr 6 holds 0x10; in the same cycle A writes 0x20 @6 and B reads @6 -> b_rdata=0x10, collision=1. A read of addr 6 on the next cycle returns 0x20.
- Reset mid-read: OUT_REG=1, issue A read of addr 0xF, assert rs one cycle later -> a_rvalid stays 0 through and after release; no stale data appears.

Source files
------------

// File: rtl/dpsram_pkg.sv
// Shared constants and types for the parametrised true dual-port RAM.
// Read-during-write mode codes and the per-port access classification live here.
package dpsram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } acc_t;

  function automatic acc_t acc_type(input logic en, input logic we);
    if (!en) return IDLE;
    return we ? WRITE : READ;
  endfunction

endpackage

// File: rtl/dpsram_rdpipe.sv
// One port's read-data/valid pipeline: one stage, or two when OUT_REG is set.
// Data registers only load on valid, so the output data holds while valid is low.
module dpsram_rdpipe #(
  parameter int W       = 8,
  parameter int OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         v1;
  logic [W-1:0] d1;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= valid_in;
      if (valid_in) d1 <= data_in;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic         v2;
    logic [W-1:0] d2;

    always_ff @(posedge clk or negedge rs) begin
      if (!rs) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign valid = v2;
    assign data  = d2;
  end else begin : g_noreg
    assign valid = v1;
    assign data  = d1;
  end

endmodule

// File: rtl/dpsram_param.sv
// Parametrised true dual-port synchronous RAM with selectable read-during-write
// behaviour, optional output register, per-port rvalid and collision detection.
module dpsram_param
  import dpsram_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic          clk,
  input  logic          rs,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          collision
);

  localparam int DEPTH = 1 << AW;

  // Ports are valid-only: rvalid marks rdata for exactly one cycle and there is
  // no ready; the consumer must take the data in that cycle.

  logic [DW-1:0] mem [DEPTH];

  acc_t a_acc, b_acc;
  logic same_addr, coll, a_wr, b_wr;

  assign a_acc     = acc_type(a_en, a_we);
  assign b_acc     = acc_type(b_en, b_we);
  assign same_addr = (a_addr == b_addr);
  assign coll      = (a_acc != IDLE) && (b_acc != IDLE) && same_addr &&
                     ((a_acc == WRITE) || (b_acc == WRITE));
  assign a_wr      = (a_acc == WRITE);
  // Port A wins a same-address dual write; B's write is dropped.
  assign b_wr      = (b_acc == WRITE) && !(a_wr && same_addr);

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      for (int i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (a_wr) mem[a_addr] <= a_wdata;
      if (b_wr) mem[b_addr] <= b_wdata;
    end
  end

  // mem is sampled before this edge's writes land, so a reader colliding with
  // the other port's write naturally sees the pre-write contents.
  logic          a_rd_valid, b_rd_valid;
  logic [DW-1:0] a_rd_data, b_rd_data;

  always_comb begin
    a_rd_valid = 1'b0;
    a_rd_data  = mem[a_addr];
    case (a_acc)
      READ:  a_rd_valid = 1'b1;
      WRITE: begin
        a_rd_valid = (RDW_MODE != RDW_NO_CHANGE);
        if (RDW_MODE == RDW_WRITE_FIRST) a_rd_data = a_wdata;
      end
      default: a_rd_valid = 1'b0;
    endcase
  end

  always_comb begin
    b_rd_valid = 1'b0;
    b_rd_data  = mem[b_addr];
    case (b_acc)
      READ:  b_rd_valid = 1'b1;
      WRITE: begin
        b_rd_valid = (RDW_MODE != RDW_NO_CHANGE);
        if (RDW_MODE == RDW_WRITE_FIRST) b_rd_data = b_wdata;
      end
      default: b_rd_valid = 1'b0;
    endcase
  end

  dpsram_rdpipe #(.W(DW), .OUT_REG(OUT_REG)) u_a_pipe (
    .clk      (clk),
    .rs       (rs),
    .valid_in (a_rd_valid),
    .data_in  (a_rd_data),
    .valid    (a_rvalid),
    .data     (a_rdata)
  );

  dpsram_rdpipe #(.W(DW), .OUT_REG(OUT_REG)) u_b_pipe (
    .clk      (clk),
    .rs       (rs),
    .valid_in (b_rd_valid),
    .data_in  (b_rd_data),
    .valid    (b_rvalid),
    .data     (b_rdata)
  );

  // Collision rides a width-1 pipe so it lines up with the colliding rvalid.
  logic coll_v;
  logic coll_d;

  dpsram_rdpipe #(.W(1), .OUT_REG(OUT_REG)) u_c_pipe (
    .clk      (clk),
    .rs       (rs),
    .valid_in (coll),
    .data_in  (coll),
    .valid    (coll_v),
    .data     (coll_d)
  );

  assign collision = coll_v & coll_d;

endmodule

// File: tb/tb_dpsram_param.sv
// Bench for dpsram_param: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE,
// READ_FIRST with output register) share stimulus and are checked against one memory model.
module tb_dpsram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs;
  logic       a_en, a_we, b_en, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic [7:0] ard [4];
  logic [7:0] brd [4];
  logic       arv [4];
  logic       brv [4];
  logic       col [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dpsram_param #(
      .DW(8), .AW(4),
      .RDW_MODE(g == 3 ? 0 : g),
      .OUT_REG(g == 3 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rs(rs),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(ard[g]), .a_rvalid(arv[g]),
      .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(brd[g]), .b_rvalid(brv[g]),
      .collision(col[g])
    );
  end

  typedef struct packed {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       c;
  } res_t;

  logic [7:0] mem_m [16];
  logic [7:0] hold_a [4];
  logic [7:0] hold_b [4];
  res_t       exp_q [$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // What one port returns for this cycle's request, from the RAM's stated rules.
  function automatic res_t predict(input int mode);
    res_t r;
    r   = '0;
    r.c = a_en && b_en && (a_addr == b_addr) && (a_we || b_we);
    if (a_en) begin
      if (!a_we || mode == 0) begin r.av = 1'b1; r.ad = mem_m[a_addr]; end
      else if (mode == 1)     begin r.av = 1'b1; r.ad = a_wdata; end
    end
    if (b_en) begin
      if (!b_we || mode == 0) begin r.bv = 1'b1; r.bd = mem_m[b_addr]; end
      else if (mode == 1)     begin r.bv = 1'b1; r.bd = b_wdata; end
    end
    return r;
  endfunction

  task automatic commit_mem();
    if (a_en && a_we) mem_m[a_addr] = a_wdata;
    if (b_en && b_we && !(a_en && a_we && a_addr == b_addr)) mem_m[b_addr] = b_wdata;
  endtask

  task automatic compare(input int i, input res_t r);
    if (r.av) hold_a[i] = r.ad;
    if (r.bv) hold_b[i] = r.bd;
    check($sformatf("d%0d a_rvalid", i), 32'(arv[i]), 32'(r.av));
    check($sformatf("d%0d a_rdata", i), 32'(ard[i]), 32'(hold_a[i]));
    check($sformatf("d%0d b_rvalid", i), 32'(brv[i]), 32'(r.bv));
    check($sformatf("d%0d b_rdata", i), 32'(brd[i]), 32'(hold_b[i]));
    check($sformatf("d%0d collision", i), 32'(col[i]), 32'(r.c));
  endtask

  task automatic step(input logic ae, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                      input logic be, input logic bw, input logic [3:0] ba, input logic [7:0] bd);
    res_t r [3];
    a_en = ae; a_we = aw; a_addr = aa; a_wdata = ad;
    b_en = be; b_we = bw; b_addr = ba; b_wdata = bd;
    @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) r[m] = predict(m);
    commit_mem();
    for (int m = 0; m < 3; m++) compare(m, r[m]);
    exp_q.push_back(r[0]);
    compare(3, exp_q.pop_front());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    a_en = 1'b0; b_en = 1'b0; a_we = 1'b0; b_we = 1'b0;
    rs = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst d%0d a_rvalid", i), 32'(arv[i]), 32'd0);
      check($sformatf("rst d%0d a_rdata", i), 32'(ard[i]), 32'd0);
      check($sformatf("rst d%0d b_rvalid", i), 32'(brv[i]), 32'd0);
      check($sformatf("rst d%0d b_rdata", i), 32'(brd[i]), 32'd0);
      check($sformatf("rst d%0d collision", i), 32'(col[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    rs = 1'b1;
    for (int k = 0; k < 16; k++) mem_m[k] = 8'h00;
    for (int i = 0; i < 4; i++) begin hold_a[i] = 8'h00; hold_b[i] = 8'h00; end
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  initial begin
    rs = 1'b1;
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #1;
    do_reset();

    // Reset clears the array.
    step(1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00);
    do_reset();
    step(1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00);
    check("reset a_rdata", 32'(ard[0]), 32'h00);
    check("reset b_rvalid", 32'(brv[0]), 32'd1);
    idle();

    // Cross-port write then read.
    step(1'b1, 1'b1, 4'h1, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00);
    step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h1, 8'h00);
    check("xport b_rdata", 32'(brd[0]), 32'h5A);
    idle();
    check("xport oreg b_rdata", 32'(brd[3]), 32'h5A);
    check("xport oreg b_rvalid", 32'(brv[3]), 32'd1);

    // Read-during-write modes.
    step(1'b1, 1'b1, 4'h2, 8'h11, 1'b0, 1'b0, 4'h0, 8'h00);
    step(1'b1, 1'b1, 4'h2, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00);
    check("rdw read_first", 32'(ard[0]), 32'h11);
    check("rdw write_first", 32'(ard[1]), 32'h77);
    check("rdw no_change rvalid", 32'(arv[2]), 32'd0);

    // Dual-write collision: A's data wins.
    step(1'b1, 1'b1, 4'h5, 8'h33, 1'b1, 1'b1, 4'h5, 8'h44);
    check("dual wr collision", 32'(col[0]), 32'd1);
    step(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    check("dual wr collision pulse", 32'(col[0]), 32'd0);
    check("dual wr stored", 32'(ard[0]), 32'h33);

    // Write/read collision: reader sees old data in every mode.
    step(1'b1, 1'b1, 4'h6, 8'h10, 1'b0, 1'b0, 4'h0, 8'h00);
    step(1'b1, 1'b1, 4'h6, 8'h20, 1'b1, 1'b0, 4'h6, 8'h00);
    check("wr/rd collision b_rdata", 32'(brd[1]), 32'h10);
    check("wr/rd collision flag", 32'(col[2]), 32'd1);
    step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00);
    check("wr/rd after", 32'(brd[0]), 32'h20);
    idle();

    // Reset while a registered read is still in flight.
    step(1'b1, 1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      check("mid reset oreg a_rvalid", 32'(arv[3]), 32'd0);
    end

    // Random traffic, biased towards same-address pairs.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] aa, ba;
      aa = 4'($urandom_range(0, 15));
      ba = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), aa, 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ba, 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
